apb_clint: RTL

//  APB3 responder implementing a core-local interruptor: 64-bit mtime counter, 64-bit mtimecmp, msip bit.

---
 rtl/apb_clint.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/apb_clint.sv
// APB3 core-local interruptor: 64-bit mtime/mtimecmp, msip, registered mti_o/msi_o.
// Optional mtime prescaler at offset 0x18 when SOPHON_CLINT_PRESCALER_EN is defined.
module apb_clint #(
  parameter int unsigned ADDR_W  = 12,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  input  logic              pwrite_i,
  input  logic              psel_i,
  input  logic              penable_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              mti_o,
  output logic              msi_o
);

  typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StDone = 2'd2} state_e;

  state_e      state_q;
  logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d, rdata;
  logic        msip_q, msip_d;
  logic        mapped, commit, wr_en, rd_en, tick;
  logic [2:0]  idx;
  logic        unused_addr;

  assign idx         = paddr_i[4:2];
  assign unused_addr = ^paddr_i[1:0];
  // Commit only if the master still selects us at the end of the wait state.
  assign commit      = (state_q == StWait) && psel_i;
  assign wr_en       = commit && pwrite_i && mapped;
  assign rd_en       = commit && !pwrite_i && mapped;

`ifdef SOPHON_CLINT_PRESCALER_EN
  logic [15:0] presc_q, presc_d, div_q, div_d;

  always_comb begin
    tick    = (div_q == presc_q);
    presc_d = presc_q;
    div_d   = tick ? 16'd0 : div_q + 16'd1;
    if (wr_en && idx == 3'd6) begin
      presc_d = pwdata_i[15:0];
      div_d   = 16'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= 16'd0;
      div_q   <= 16'd0;
    end else begin
      presc_q <= presc_d;
      div_q   <= div_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    mapped = (paddr_i[ADDR_W-1:5] == '0);
    rdata  = '0;
    case (idx)
      3'd0: rdata = {31'd0, msip_q};
      3'd2: rdata = cmp_q[31:0];
      3'd3: rdata = cmp_q[63:32];
      3'd4: rdata = mtime_q[31:0];
      3'd5: rdata = shadow_q;
`ifdef SOPHON_CLINT_PRESCALER_EN
      3'd6: rdata = {16'd0, presc_q};
`endif
      default: mapped = 1'b0;
    endcase
    if (!mapped) rdata = '0;
  end

  always_comb begin
    msip_d   = msip_q;
    cmp_d    = cmp_q;
    shadow_d = shadow_q;
    mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
    // A half-write replaces the increment; the other half holds without carry.
    if (wr_en) begin
      case (idx)
        3'd0:    msip_d = pwdata_i[0];
        3'd2:    cmp_d[31:0] = pwdata_i;
        3'd3:    cmp_d[63:32] = pwdata_i;
        3'd4:    mtime_d = {mtime_q[63:32], pwdata_i};
        3'd5:    mtime_d = {pwdata_i, mtime_q[31:0]};
        default: ;
      endcase
    end
    if (rd_en && idx == 3'd4) shadow_d = mtime_q[63:32];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q  <= 64'd0;
      cmp_q    <= CMP_RST;
      shadow_q <= 32'd0;
      msip_q   <= 1'b0;
      mti_o    <= 1'b0;
      msi_o    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      msip_q   <= msip_d;
      mti_o    <= (mtime_q >= cmp_q);
      msi_o    <= msip_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      prdata_o  <= 32'd0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (psel_i && penable_i) state_q <= StWait;
        StWait: begin
          if (psel_i) begin
            state_q   <= StDone;
            pready_o  <= 1'b1;
            prdata_o  <= pwrite_i ? 32'd0 : rdata;
            pslverr_o <= !mapped;
          end else begin
            state_q <= StIdle;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          pready_o  <= 1'b0;
          pslverr_o <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
